// File: rtl/dmi_arbiter_serv.sv
// Shares one debug-module DMI port between two DMI masters: round-robin grant,
// one outstanding transaction, response routed to its issuer, timeout with late-response drain.
module dmi_arbiter_serv #(
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [40:0] req0_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  output logic [33:0] resp0_o,
  output logic        resp0_valid_o,
  input  logic        resp0_ready_i,
  input  logic [40:0] req1_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  output logic [33:0] resp1_o,
  output logic        resp1_valid_o,
  input  logic        resp1_ready_i,
  output logic [40:0] dmi_req_o,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  input  logic [33:0] dmi_resp_i,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  output logic        owner_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned CntW = (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam bit TimeoutEn = (TimeoutCycles != 0);
  localparam logic [CntW-1:0] TimeoutLimit = CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);

  typedef enum logic [2:0] {
    Idle,
    Issue,
    WaitResp,
    Respond,
    Drain
  } state_e;

  state_e          state_q;
  logic [40:0]     req_q;
  logic [33:0]     resp_q;
  logic [CntW-1:0] cnt_q;
  logic            owner_q;
  logic            last_q;
  logic            drain_q;
  logic            dmi_req_valid_q;
  logic            dmi_resp_ready_q;
  logic            resp0_valid_q;
  logic            resp1_valid_q;
  logic            busy_q;

  logic idle;
  logic gnt0;
  logic gnt1;
  logic timeout_hit;
  logic resp_hs;

  // On contention the requester that was not served last wins.
  assign idle        = (state_q == Idle);
  assign gnt0        = idle && req0_valid_i && (!req1_valid_i || last_q);
  assign gnt1        = idle && req1_valid_i && (!req0_valid_i || !last_q);
  assign timeout_hit = TimeoutEn && (state_q == WaitResp) && !dmi_resp_valid_i &&
                       (cnt_q == TimeoutLimit);
  assign resp_hs     = owner_q ? resp1_ready_i : resp0_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q          <= Idle;
      req_q            <= '0;
      resp_q           <= '0;
      cnt_q            <= '0;
      owner_q          <= 1'b0;
      last_q           <= 1'b1;  // pretend requester 1 went last so requester 0 is preferred
      drain_q          <= 1'b0;
      dmi_req_valid_q  <= 1'b0;
      dmi_resp_ready_q <= 1'b0;
      resp0_valid_q    <= 1'b0;
      resp1_valid_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (gnt0 || gnt1) begin
            req_q           <= gnt1 ? req1_i : req0_i;
            owner_q         <= gnt1;
            dmi_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
            state_q         <= Issue;
          end
        end
        Issue: begin
          if (dmi_req_ready_i) begin
            cnt_q            <= '0;
            dmi_req_valid_q  <= 1'b0;
            dmi_resp_ready_q <= 1'b1;
            state_q          <= WaitResp;
          end
        end
        WaitResp: begin
          cnt_q <= cnt_q + CntW'(1);
          // A response arriving on the limit cycle beats the timeout.
          if (dmi_resp_valid_i || timeout_hit) begin
            resp_q           <= dmi_resp_valid_i ? dmi_resp_i : {32'h0, 2'h2};
            drain_q          <= !dmi_resp_valid_i;
            dmi_resp_ready_q <= 1'b0;
            resp0_valid_q    <= !owner_q;
            resp1_valid_q    <= owner_q;
            state_q          <= Respond;
          end
        end
        Respond: begin
          if (resp_hs) begin
            last_q        <= owner_q;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            if (drain_q) begin
              dmi_resp_ready_q <= 1'b1;
              state_q          <= Drain;
            end else begin
              busy_q  <= 1'b0;
              state_q <= Idle;
            end
          end
        end
        Drain: begin
          // The late response belongs to a transaction already answered with an error.
          if (dmi_resp_valid_i) begin
            drain_q          <= 1'b0;
            dmi_resp_ready_q <= 1'b0;
            busy_q           <= 1'b0;
            state_q          <= Idle;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign req0_ready_o     = gnt0;
  assign req1_ready_o     = gnt1;
  assign resp0_o          = resp_q;
  assign resp1_o          = resp_q;
  assign resp0_valid_o    = resp0_valid_q;
  assign resp1_valid_o    = resp1_valid_q;
  assign dmi_req_o        = req_q;
  assign dmi_req_valid_o  = dmi_req_valid_q;
  assign dmi_resp_ready_o = dmi_resp_ready_q;
  assign owner_o          = owner_q;
  assign busy_o           = busy_q;
  assign timeout_o        = timeout_hit;

endmodule

// File: tb/tb_dmi_arbiter_serv.sv
// Randomized scoreboard bench for dmi_arbiter_serv: a transaction-level model predicts
// grants, forwarded requests, routed responses, timeouts and drains.
module tb_dmi_arbiter_serv;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [40:0] req0_i, req1_i, dmi_req_o;
  logic        req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
  logic [33:0] resp0_o, resp1_o, dmi_resp_i;
  logic        resp0_valid_o, resp1_valid_o, resp0_ready_i, resp1_ready_i;
  logic        dmi_req_valid_o, dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_ready_o;
  logic        owner_o, busy_o, timeout_o;

  always #5 clk_i = ~clk_i;

  dmi_arbiter_serv #(.TimeoutCycles(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req0_i(req0_i), .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .resp0_o(resp0_o), .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i),
    .req1_i(req1_i), .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .resp1_o(resp1_o), .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i),
    .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o),
    .owner_o(owner_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Stimulus controls
  logic [40:0] src0_q[$], src1_q[$];
  bit rnd_mode = 0;
  int dm_lat   = 1;
  int dm_stall = 0;
  int rstall0  = 0;
  int rstall1  = 0;

  // Reference model state
  logic [40:0] exp_dmi_q[$];
  logic [33:0] exp_r0_q[$], exp_r1_q[$];
  int  gnt_log[$];
  bit  m_busy = 0, m_owner = 0, m_last = 1, m_waiting = 0, m_drain = 0, m_resp_pend = 0;
  int  m_wcnt = 0;
  int  n_timeouts = 0;

  function automatic logic [40:0] rnd_req();
    return {7'($urandom_range(0, 127)), 2'($urandom_range(0, 3)), 32'($urandom())};
  endfunction

  // Requester 0 driver
  initial begin : drv0
    bit hs;
    req0_valid_i = 1'b0;
    req0_i = '0;
    forever begin
      @(negedge clk_i);
      hs = req0_valid_i && req0_ready_o && rst_ni;
      @(posedge clk_i);
      #1;
      if (hs) req0_valid_i = 1'b0;
      if (!req0_valid_i && src0_q.size() != 0 && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
        req0_i = src0_q.pop_front();
        req0_valid_i = 1'b1;
      end
    end
  end

  // Requester 1 driver
  initial begin : drv1
    bit hs;
    req1_valid_i = 1'b0;
    req1_i = '0;
    forever begin
      @(negedge clk_i);
      hs = req1_valid_i && req1_ready_o && rst_ni;
      @(posedge clk_i);
      #1;
      if (hs) req1_valid_i = 1'b0;
      if (!req1_valid_i && src1_q.size() != 0 && (!rnd_mode || $urandom_range(0, 2) == 0)) begin
        req1_i = src1_q.pop_front();
        req1_valid_i = 1'b1;
      end
    end
  end

  // Response-ready drivers
  initial begin : rdy
    resp0_ready_i = 1'b1;
    resp1_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (rstall0 > 0) begin
        resp0_ready_i = 1'b0;
        if (resp0_valid_o) rstall0--;
      end else resp0_ready_i = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rstall1 > 0) begin
        resp1_ready_i = 1'b0;
        if (resp1_valid_o) rstall1--;
      end else resp1_ready_i = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Debug-module model: response arrives in the Nth cycle after the request handshake
  initial begin : dm
    bit rq_hs, rs_hs, in_rst, pend;
    int cd;
    pend = 0;
    cd = 0;
    dmi_req_ready_i  = 1'b1;
    dmi_resp_valid_i = 1'b0;
    dmi_resp_i       = '0;
    forever begin
      @(negedge clk_i);
      rq_hs  = dmi_req_valid_o && dmi_req_ready_i && rst_ni;
      rs_hs  = dmi_resp_valid_i && dmi_resp_ready_o && rst_ni;
      in_rst = !rst_ni;
      @(posedge clk_i);
      #1;
      if (in_rst) begin
        pend = 0;
        dmi_resp_valid_i = 1'b0;
      end else begin
        if (rs_hs) dmi_resp_valid_i = 1'b0;
        if (rq_hs) begin
          pend = 1;
          cd = (dm_lat != 0) ? dm_lat : int'($urandom_range(1, 12));
        end
        if (pend) begin
          cd--;
          if (cd == 0) begin
            pend = 0;
            dmi_resp_valid_i = 1'b1;
            dmi_resp_i = {32'($urandom()), 2'($urandom_range(0, 3))};
          end
        end
      end
      if (dmi_req_valid_o && dm_stall > 0) begin
        dmi_req_ready_i = 1'b0;
        dm_stall--;
      end else dmi_req_ready_i = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor and scoreboard
  always @(negedge clk_i) begin : mon
    bit exp_dv, exp_rr, exp_to, g0, g1, ev0, ev1, drain_done, rhs;
    if (!rst_ni) begin
      m_busy = 0; m_owner = 0; m_last = 1; m_waiting = 0; m_drain = 0; m_resp_pend = 0; m_wcnt = 0;
      exp_dmi_q.delete();
      exp_r0_q.delete();
      exp_r1_q.delete();
    end else begin
      exp_dv     = m_busy && exp_dmi_q.size() != 0;
      exp_rr     = m_waiting || (m_drain && !m_resp_pend);
      exp_to     = m_waiting && (m_wcnt + 1 == TO) && !dmi_resp_valid_i;
      g0         = !m_busy && req0_valid_i && (!req1_valid_i || m_last);
      g1         = !m_busy && req1_valid_i && (!req0_valid_i || !m_last);
      ev0        = m_resp_pend && !m_owner;
      ev1        = m_resp_pend && m_owner;
      drain_done = m_drain && !m_resp_pend && dmi_resp_valid_i;
      rhs        = (ev0 && resp0_ready_i) || (ev1 && resp1_ready_i);

      chk("busy", busy_o, m_busy);
      chk("owner", owner_o, m_owner);
      chk("grant", {req1_ready_o, req0_ready_o}, {g1, g0});
      chk("dmi_req_valid", dmi_req_valid_o, exp_dv);
      chk("dmi_resp_ready", dmi_resp_ready_o, exp_rr);
      chk("timeout", timeout_o, exp_to);
      chk("resp_valids", {resp1_valid_o, resp0_valid_o}, {ev1, ev0});
      if (exp_dv && dmi_req_valid_o) chk("dmi_req", dmi_req_o, exp_dmi_q[0]);
      if (ev0 && resp0_valid_o && exp_r0_q.size() != 0) chk("resp0", resp0_o, exp_r0_q[0]);
      if (ev1 && resp1_valid_o && exp_r1_q.size() != 0) chk("resp1", resp1_o, exp_r1_q[0]);

      if (g0 || g1) begin
        exp_dmi_q.push_back(g1 ? req1_i : req0_i);
        m_owner = g1;
        m_busy  = 1;
        gnt_log.push_back(int'(g1));
      end
      if (exp_dv && dmi_req_ready_i) begin
        void'(exp_dmi_q.pop_front());
        m_waiting = 1;
        m_wcnt = 0;
      end else if (m_waiting) begin
        m_wcnt++;
        if (dmi_resp_valid_i || exp_to) begin
          if (m_owner) exp_r1_q.push_back(dmi_resp_valid_i ? dmi_resp_i : {32'h0, 2'h2});
          else         exp_r0_q.push_back(dmi_resp_valid_i ? dmi_resp_i : {32'h0, 2'h2});
          m_waiting = 0;
          m_resp_pend = 1;
          if (exp_to) begin
            m_drain = 1;
            n_timeouts++;
          end
        end
      end
      if (rhs) begin
        if (m_owner) void'(exp_r1_q.pop_front());
        else         void'(exp_r0_q.pop_front());
        m_resp_pend = 0;
        m_last = m_owner;
        if (!m_drain) m_busy = 0;
      end
      if (drain_done) begin
        m_drain = 0;
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #2;
  endtask

  task automatic pulse_reset();
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      done = src0_q.size() == 0 && src1_q.size() == 0 && !req0_valid_i && !req1_valid_i && !m_busy;
    end
    chk(tag, done, 1'b1);
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: got no finish want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    int bc, t0;
    bit seen;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_dmi_req_valid", dmi_req_valid_o, 1'b0);
    chk("rst_dmi_resp_ready", dmi_resp_ready_o, 1'b0);
    chk("rst_resp_valids", {resp1_valid_o, resp0_valid_o}, 2'b00);
    chk("rst_timeout", timeout_o, 1'b0);

    // Single read, zero-latency DM
    src0_q.push_back({7'h11, 2'h1, 32'h0});
    bc = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy_o) begin
        seen = 1;
        bc++;
      end else if (seen) break;
    end
    chk("single_busy_cycles", bc, 3);

    // Contention after reset: 0, 1, 0, 1
    pulse_reset();
    gnt_log.delete();
    src0_q.push_back({7'h20, 2'h1, 32'h0});
    src1_q.push_back({7'h10, 2'h2, 32'h1});
    src0_q.push_back({7'h21, 2'h2, 32'hCAFE});
    src1_q.push_back({7'h22, 2'h0, 32'h0});
    wait_idle(200, "contention_idle");
    chk("contention_order", {gnt_log.size() == 4 ? gnt_log[0] : 9, gnt_log.size() == 4 ? gnt_log[1] : 9,
        gnt_log.size() == 4 ? gnt_log[2] : 9, gnt_log.size() == 4 ? gnt_log[3] : 9}, {32'd0, 32'd1});
    chk("contention_order_tail", gnt_log.size() == 4 ? {gnt_log[2], gnt_log[3]} : 64'hF, {32'd0, 32'd1});

    // Stalls on both handshakes while requester 1 waits
    dm_stall = 5;
    rstall0 = 3;
    src0_q.push_back({7'h30, 2'h2, 32'h12345678});
    src1_q.push_back({7'h31, 2'h1, 32'h0});
    wait_idle(200, "stall_idle");

    // Timeout with a late response that must be absorbed before the next grant
    t0 = n_timeouts;
    dm_lat = 20;
    src1_q.push_back({7'h40, 2'h1, 32'h0});
    for (int i = 0; i < 60 && n_timeouts == t0; i++) tick();
    dm_lat = 1;
    src0_q.push_back({7'h41, 2'h1, 32'h0});
    wait_idle(200, "timeout_idle");
    chk("timeout_fired", n_timeouts - t0, 1);

    // Response exactly on the limit cycle wins; one cycle later times out
    t0 = n_timeouts;
    dm_lat = TO;
    src0_q.push_back({7'h50, 2'h1, 32'h0});
    wait_idle(200, "boundary_idle");
    chk("boundary_no_timeout", n_timeouts - t0, 0);
    dm_lat = TO + 1;
    src1_q.push_back({7'h51, 2'h1, 32'h0});
    wait_idle(200, "beyond_idle");
    chk("beyond_timeout", n_timeouts - t0, 1);
    dm_lat = 1;

    // Reset while a requester-1 request sits in Issue
    dm_stall = 1000;
    src1_q.push_back({7'h60, 2'h2, 32'h77});
    for (int i = 0; i < 40 && !dmi_req_valid_o; i++) tick();
    chk("issue_reached", dmi_req_valid_o, 1'b1);
    pulse_reset();
    dm_stall = 0;
    chk("midrst_valids", {dmi_req_valid_o, resp1_valid_o, resp0_valid_o}, 3'b000);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_owner", owner_o, 1'b0);
    gnt_log.delete();
    src0_q.push_back({7'h61, 2'h1, 32'h0});
    src1_q.push_back({7'h62, 2'h1, 32'h0});
    wait_idle(200, "midrst_idle");
    chk("midrst_first_grant", gnt_log.size() != 0 ? gnt_log[0] : 9, 0);

    // Randomized traffic
    rnd_mode = 1;
    dm_lat = 0;
    for (int i = 0; i < 60; i++) begin
      src0_q.push_back(rnd_req());
      src1_q.push_back(rnd_req());
    end
    wait_idle(20000, "random_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter_serv.md
Name: dmi_arbiter_serv

Overview:
- Core-clock-domain arbiter that shares the single debug-module DMI port between two DMI masters.
- Requester 0 is the JTAG DTM, after its CDC. Requester 1 is a second debug master, e.g. a UART/bus debug bridge.
- Allows one outstanding transaction at a time, with round-robin grant.
- Routes each response back to the requester that issued it.
- A response timeout returns an error to the requester and absorbs the late response.

Parameters:
- TimeoutCycles, 1023: cycles spent in WaitResp before a synthetic error response is generated; 0 disables the timeout.
- CntW, $clog2(TimeoutCycles+1) (minimum 1): timeout counter width; derived, not overridden.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- req0_i  in  41  dm::dmi_req_t {addr[6:0], op[1:0], data[31:0]} from requester 0
- req0_valid_i  in  1  request valid, requester 0
- req0_ready_o  out  1  request accepted, requester 0
- resp0_o  out  34  dm::dmi_resp_t {data[31:0], resp[1:0]} to requester 0
- resp0_valid_o  out  1  response valid to requester 0
- resp0_ready_i  in  1  requester 0 accepts response
- req1_i, req1_valid_i, req1_ready_o, resp1_o, resp1_valid_o, resp1_ready_i: as above, requester 1
- dmi_req_o  out  41  request to debug module
- dmi_req_valid_o  out  1  request valid to debug module
- dmi_req_ready_i  in  1  debug module accepts request
- dmi_resp_i  in  34  response from debug module
- dmi_resp_valid_i  in  1  debug module response valid
- dmi_resp_ready_o  out  1  arbiter accepts response
- owner_o  out  1  index of the current or last granted requester
- busy_o  out  1  high whenever state != Idle
- timeout_o  out  1  single-cycle pulse when a timeout fires

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is synchronous, active-low.
- Reset: state Idle, all valid/ready outputs 0, owner_o 0, busy_o 0, timeout_o 0.
- Reset (cont.): round-robin pointer prefers requester 0; counter 0; drain flag 0; holding registers 0.
- Reset mid-operation: abandons the transaction. Any later debug-module response is not tracked.
- States: Idle, Issue, WaitResp, Respond, Drain.
- Idle, grant selection:
  - If exactly one reqN_valid_i is high, grant it.
  - If both are high, grant the one not granted last.
  - reqN_ready_o is driven combinationally high for the granted requester only in this cycle.
  - req is latched into the holding register, owner updated, next state Issue.
- Idle, accept latency: accept in cycle T gives dmi_req_valid_o high from T+1.
- Issue:
  - dmi_req_valid_o=1 and dmi_req_o = held value, stable until dmi_req_ready_i.
  - On handshake: counter cleared, next state WaitResp.
- WaitResp, signals: dmi_resp_ready_o=1; counter increments each cycle.
- WaitResp, on dmi_resp_valid_i: capture dmi_resp_i into the response register, go to Respond.
- WaitResp, timeout: if TimeoutCycles!=0, counter==TimeoutCycles-1 and no resp valid:
  - response register = {32'h0, 2'h2} (op failed);
  - timeout_o=1 for one cycle; drain flag set; go to Respond.
- WaitResp, simultaneous valid and limit: the response wins and no timeout fires.
- Respond:
  - respN_valid_o=1 for the owner only; the other valid stays 0. resp is held stable.
  - On respN_ready_i: round-robin "last granted" = owner.
  - Next state is Drain if the drain flag is set, else Idle.
  - dmi_resp_ready_o=0 in this state.
- Drain: dmi_resp_ready_o=1; no new grants, no timeout. On dmi_resp_valid_i, clear the drain flag and go to Idle. Response data is discarded.
- Non-owner requester: its ready stays 0 outside its grant cycle. Its request must be held by it (valid/ready protocol, no retraction assumed by the arbiter).
- Minimum transaction time: with zero-latency DM handshakes, one transaction takes 4 cycles (Idle, Issue, WaitResp, Respond); a new grant is possible in the 5th.
- Pass-through: op is not interpreted. NOP, read and write are forwarded unchanged; addr and data are bit-exact.
- owner_o: holds its value after Respond until the next grant.
- dmi_req_valid_o: never high outside Issue.
- Outstanding requests: at most one request is outstanding toward the debug module.

Test Plan:
- Single read: req0 {addr 7'h11, op 2'h1, data 0} with DM returning {32'hDEADBEEF, 2'h0} next cycle.
  -> dmi_req_o equals req0; resp0_o {DEADBEEF, 0}; resp1_valid_o never high; busy_o high for 3 cycles.
- Contention: both valid in the same cycle after reset.
  -> req0 granted first, then req1 (addr 7'h10 write 32'h1) on the next Idle; third contention grants req0.
- Stall: dmi_req_ready_i held low 5 cycles, then resp0_ready_i low 3 cycles.
  -> dmi_req_o and resp0_o stable; req1 ready stays 0 throughout.
- Timeout: TimeoutCycles=8, DM never responds.
  -> timeout_o pulses 8 cycles after request handshake; resp1_o {0, 2'h2}.
  -> state goes to Drain; a late DM response {32'h5, 0} is absorbed; the next grant only occurs after it.
- Response on timeout boundary: TimeoutCycles=8, resp valid in exactly the 8th WaitResp cycle.
  -> real data returned, timeout_o stays 0, no Drain.
- Reset mid-Issue: rst_ni low one cycle.
  -> next cycle all valids 0, busy_o 0, owner_o 0; the following grant prefers req0.
